// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg (package)
//  Description : Shared constants and types for the 8-digit 7-segment scan
//                driver: blank pattern, active-low segment table, and the
//                {digits,en} frame word held in the shadow/active buffers.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Number of digits on the display; the anode bus width follows this.
    localparam int NDIG = 8;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value.
    // Entry 15 is listed first because this is a packed array.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // One display frame: nibble k of digits drives digit k, en[k] lights it.
    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  en;
    } frame_t;

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg7
//  Description : Combinational nibble to active-low 7-segment decoder.
//  Ports       : nib_i [3:0]  hex digit value
//                seg_o [6:0]  {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed driver for an 8-digit common-anode
//                7-segment display. New values are captured into a shadow
//                buffer on load and copied to the active buffer only at the
//                end of a scan frame, so a frame never mixes old and new data.
//  Ports       : clk          system clock
//                rst          synchronous reset, active-high
//                digits [31:0] nibble k shows on digit k (digit 0 rightmost)
//                en     [7:0]  en[k]=1 lights digit k
//                load         1-cycle strobe, captures digits/en into shadow
//                pending      shadow holds data not yet applied
//                hex    [6:0]  {g,f,e,d,c,b,a}, active-low
//                AN     [7:0]  anode strobes, active-low
//  Parameters  : DIV          clk cycles per digit slot (>= 2)
//  Options     : SEG7_LEAD_ZERO_BLANK_EN - when defined, enabled digits above
//                the highest nonzero enabled digit are blanked (digit 0 is
//                always kept so a zero value still reads "0").
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      digits,
    input  logic [NDIG-1:0]  en,
    input  logic             load,
    output logic             pending,
    output logic [6:0]       hex,
    output logic [NDIG-1:0]  AN
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(NDIG);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    frame_t           shadow_q,  shadow_d;
    frame_t           active_q,  active_d;
    logic             pending_q, pending_d;
    logic [6:0]       hex_q,     hex_d;
    logic [NDIG-1:0]  an_q,      an_d;

    logic             tick;
    logic             boundary;
    logic [NDIG-1:0]  en_eff;
    logic [3:0]       nib_cur;
    logic [6:0]       seg_cur;

    assign tick     = (cnt_q == CNT_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);

    // ------------------------------------------------------------------
    // Effective enable mask for the active buffer
    // ------------------------------------------------------------------
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    logic [NDIG-1:0] keep;
    logic            seen;

    // Scan from the top digit down; once a nonzero enabled digit has been
    // seen, it and everything below it stay lit.
    always_comb begin
        keep = '0;
        seen = 1'b0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            if (active_q.en[k] && (active_q.digits[4*k +: 4] != 4'h0)) begin
                seen = 1'b1;
            end
            keep[k] = seen;
        end
        keep[0] = 1'b1;
        en_eff  = active_q.en & keep;
    end
`else
    assign en_eff = active_q.en;
`endif

    // ------------------------------------------------------------------
    // Current digit decode
    // ------------------------------------------------------------------
    assign nib_cur = active_q.digits[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nib_i (nib_cur),
        .seg_o (seg_cur)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d     = tick ? idx_q + IDX_W'(1) : idx_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;

        // The boundary uses the shadow as it was before this edge; a load on
        // the same edge therefore lands in the shadow for the next frame.
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = '{digits: digits, en: en};
            pending_d = 1'b1;
        end

        an_d  = ~((NDIG'(1) << idx_q) & en_eff);
        hex_d = en_eff[idx_q] ? seg_cur : SEG_BLANK;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            hex_q     <= SEG_BLANK;
            an_q      <= '1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            hex_q     <= hex_d;
            an_q      <= an_d;
        end
    end

    assign pending = pending_q;
    assign hex     = hex_q;
    assign AN      = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Directed self-checking bench for seg7_scan_driver (DIV=4).
//                Expected values come from a local segment table and a
//                frame-position counter kept by the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int DIV = 4;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] digits;
    logic [7:0]  en;
    logic        load;
    logic        pending;
    logic [6:0]  hex;
    logic [7:0]  AN;

    int checks = 0;
    int errors = 0;
    int phase  = 0;   // clock edges since reset release

    seg7_scan_driver #(.DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .digits  (digits),
        .en      (en),
        .load    (load),
        .pending (pending),
        .hex     (hex),
        .AN      (AN)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [7:0] eff_en(input logic [31:0] d, input logic [7:0] e);
        logic [7:0] r;
        r = e;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        for (int k = 7; k >= 1; k--) begin
            if (e[k] && d[4*k +: 4] != 4'h0) break;
            r[k] = 1'b0;
        end
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at phase %0d: observed=%h expected=%h", tag, phase, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        phase++;
    endtask

    task automatic goto_phase(input int p);
        while (phase < p) cyc();
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] e);
        digits = d;
        en     = e;
        load   = 1'b1;
        cyc();
        load   = 1'b0;
    endtask

    // Called right after a frame boundary edge; checks every cycle of the
    // following frame against the given frame contents.
    task automatic check_frame(input logic [31:0] d, input logic [7:0] e);
        logic [7:0] ee;
        logic [7:0] exp_an;
        logic [6:0] exp_hex;
        ee = eff_en(d, e);
        for (int s = 0; s < 8; s++) begin
            exp_an  = ee[s] ? ~(8'h01 << s) : 8'hFF;
            exp_hex = ee[s] ? seg_of(d[4*s +: 4]) : 7'h7F;
            for (int r = 0; r < DIV; r++) begin
                cyc();
                chk("AN", AN, exp_an);
                chk("hex", {1'b0, hex}, {1'b0, exp_hex});
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        digits = '0;
        en     = '0;

        // 1. reset
        repeat (3) cyc();
        chk("rst_hex", {1'b0, hex}, 8'h7F);
        chk("rst_AN", AN, 8'hFF);
        chk("rst_pending", {7'b0, pending}, 8'h00);
        rst   = 1'b0;
        phase = 0;
        repeat (2) cyc();
        chk("dark_hex", {1'b0, hex}, 8'h7F);
        chk("dark_AN", AN, 8'hFF);
        chk("dark_pending", {7'b0, pending}, 8'h00);

        // 2. full frame of 89ABCDEF
        do_load(32'h89ABCDEF, 8'hFF);
        chk("pend_set", {7'b0, pending}, 8'h01);
        goto_phase(FRAME - 1);
        chk("pend_hold", {7'b0, pending}, 8'h01);
        chk("pre_AN", AN, 8'hFF);
        cyc();
        chk("pend_clr", {7'b0, pending}, 8'h00);
        check_frame(32'h89ABCDEF, 8'hFF);

        // 3. sparse enable mask
        do_load(32'h00000031, 8'b0000_0101);
        chk("pend3", {7'b0, pending}, 8'h01);
        goto_phase(3 * FRAME);
        chk("pend3_clr", {7'b0, pending}, 8'h00);
        check_frame(32'h00000031, 8'b0000_0101);

        // 4a. last load in a frame wins
        do_load(32'h12345678, 8'hFF);
        repeat (3) cyc();
        do_load(32'h00000042, 8'hFF);
        goto_phase(5 * FRAME);
        check_frame(32'h00000042, 8'hFF);

        // 4b. load on the boundary edge is deferred one frame
        do_load(32'h0000BEEF, 8'h0F);
        goto_phase(7 * FRAME - 1);
        do_load(32'h000000A5, 8'h03);
        chk("pend_bnd", {7'b0, pending}, 8'h01);
        check_frame(32'h0000BEEF, 8'h0F);
        chk("pend_bnd_clr", {7'b0, pending}, 8'h00);
        check_frame(32'h000000A5, 8'h03);

        // 5. reset mid-frame at idx 4 discards the pending shadow
        do_load(32'h00000042, 8'hFF);
        goto_phase(9 * FRAME + 4 * DIV + 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_AN", AN, 8'hFF);
        chk("mid_rst_hex", {1'b0, hex}, 8'h7F);
        chk("mid_rst_pending", {7'b0, pending}, 8'h00);
        phase = 0;
        for (int i = 0; i < FRAME + 8; i++) begin
            cyc();
            chk("post_rst_AN", AN, 8'hFF);
        end
        do_load(32'h01234567, 8'hFF);
        goto_phase(2 * FRAME);
        check_frame(32'h01234567, 8'hFF);

        // 6. leading-zero patterns (blanked only when the option is built in)
        do_load(32'h00000305, 8'hFF);
        goto_phase(4 * FRAME);
        check_frame(32'h00000305, 8'hFF);
        do_load(32'h00000000, 8'hFF);
        goto_phase(6 * FRAME);
        check_frame(32'h00000000, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
